// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the MIPS HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fix-up cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             rd_req,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             stall,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_mark_q, dbz_mark_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Issue decode: even ops (MULT, DIV) are signed.
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_part, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & op_a[WIDTH-1];
    b_neg     = op_signed & op_b[WIDTH-1];
    abs_a     = a_neg ? -op_a : op_a;
    abs_b     = b_neg ? -op_b : op_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, b_q = multiplicand.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}, b_q = divisor.
    div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_part >= {1'b0, b_q};
    div_diff = div_part - {1'b0, b_q};
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    a_orig_d   = a_orig_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_mark_d = dbz_mark_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d   = op[1];
              neg_res_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              a_orig_d   = op_a;
              cnt_d      = '0;
              acc_d      = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
              b_d        = op[1] ? abs_b : abs_a;
              dbz_mark_d = op[1] && (op_b == '0);
              state_d    = (op[1] && (op_b == '0)) ? S_FIX : S_RUN;
            end
            3'b100:  hi_d = op_a;
            3'b101:  lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dbz_mark_q) begin
            lo_d  = '1;
            hi_d  = a_orig_q;
            dbz_d = 1'b1;
          end else begin
            lo_d  = quo_fix;
            hi_d  = rem_fix;
            dbz_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      a_orig_q   <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_mark_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      a_orig_q   <= a_orig_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_mark_q <= dbz_mark_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign rd_data   = rd_hi ? hi_q : lo_q;
  assign stall     = busy_q & (start | rd_req);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table, hazard/cancel sequences, and random ops
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk, rst_n, start, flush, rd_req, rd_hi;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b, rd_data, hi, lo;
  logic         busy, done, dbz, stall;
  logic [1:0]   dbg_state;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .rd_req(rd_req), .rd_hi(rd_hi), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz), .stall(stall),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[11];

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural state.
  function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    logic [63:0] u;
    logic [W-1:0] h, l;
    logic d;
    h = m_hi; l = m_lo; d = m_dbz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin r = sa * sb; {h, l} = r; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; {h, l} = u; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          h = a; l = '1; d = 1'b1;
        end else if (o == 3'd2) begin
          l = 32'(sa / sb); h = 32'(sa % sb); d = 1'b0;
        end else begin
          l = a / b; h = a % b; d = 1'b0;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
    return {d, h, l};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W:0] e);
    logic [2*W:0] ex;
    int n, lat;
    bit busy_ok;
    exp_q.push_back(e);
    issue(o, a, b);
    if (o <= 3'd3) begin
      lat = (o[1] && b == 0) ? 1 : W + 1;
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 100) begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " busy_in_flight"}, 64'(busy_ok), 64'd1);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    end else begin
      check({tag, " busy_after_move"}, 64'(busy), 64'd0);
      check({tag, " done_after_move"}, 64'(done), 64'd0);
    end
    ex = exp_q.pop_front();
    check({tag, " hi"}, 64'(hi), 64'(ex[2*W-1:W]));
    check({tag, " lo"}, 64'(lo), 64'(ex[W-1:0]));
    check({tag, " dbz"}, 64'(dbz), 64'(ex[2*W]));
    m_dbz = ex[2*W]; m_hi = ex[2*W-1:W]; m_lo = ex[W-1:0];
    if (o <= 3'd3) begin
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    int n;
    bit ok, seen;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[6]  = '{3'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{3'd0, 32'd3,        32'd4,        32'd0,        32'd12,       1'b1};
    vecs[8]  = '{3'd3, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
    vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; rd_req = 1'b0; rd_hi = 1'b0;
    op = 3'd0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].dbz, vecs[i].hi, vecs[i].lo});

    // Hazard: MFLO and MTHI held while a MULT runs.
    issue(3'd0, 32'd3, 32'd5);
    start = 1'b1; op = 3'd4; op_a = 32'h1234; op_b = '0; rd_req = 1'b1; rd_hi = 1'b0;
    n = 0; ok = 1'b1;
    while (busy && n < 100) begin
      if (!stall) ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("hazard stall_while_busy", 64'(ok), 64'd1);
    check("hazard wait_cycles", 64'(n), 64'(W + 1));
    check("hazard stall_released", 64'(stall), 64'd0);
    check("hazard rd_data_lo", 64'(rd_data), 64'd15);
    @(posedge clk); #1;
    start = 1'b0; rd_req = 1'b0;
    check("hazard mthi_hi", 64'(hi), 64'h1234);
    check("hazard mthi_lo", 64'(lo), 64'd15);
    m_hi = 32'h1234; m_lo = 32'd15;

    // Flush in IDLE blocks a simultaneous MTHI.
    flush = 1'b1;
    issue(3'd4, 32'hDEAD, 32'd0);
    flush = 1'b0;
    check("idle_flush hi", 64'(hi), 64'(m_hi));

    // Cancellation from HI=0xAAAA, LO=0x5555 with dbz set.
    run_op("pre_dbz", 3'd3, 32'd77, 32'd0, model(3'd3, 32'd77, 32'd0));
    run_op("pre_mthi", 3'd4, 32'hAAAA, 32'd0, model(3'd4, 32'hAAAA, 32'd0));
    run_op("pre_mtlo", 3'd5, 32'h5555, 32'd0, model(3'd5, 32'h5555, 32'd0));
    issue(3'd0, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'hAAAA);
    check("flush lo", 64'(lo), 64'h5555);
    check("flush dbz", 64'(dbz), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no_done", 64'(seen), 64'd0);

    issue(3'd0, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst dbz", 64'(dbz), 64'd0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(posedge clk); #1;

    // Random ops against the reference model.
    for (int i = 0; i < 25; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply uses iterative shift-add and divide uses iterative restoring division, so no single-cycle `*`, `/` or `%` sits in the EX path. It exports `busy` and `stall` to hazard control so that MFHI/MFLO and new mul/div issues wait for completion.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  issue strobe from EX; sampled with `op`, `op_a`, `op_b`.
- `op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- `op_a`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `op_b`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  pipeline flush; cancels any operation in flight.
- `rd_req`  in  1  MFHI/MFLO present in EX.
- `rd_hi`  in  1  1 = read HI, 0 = read LO.
- `rd_data`  out  WIDTH  combinational mux of the `hi`/`lo` registers.
- `hi`, `lo`  out  WIDTH each  architectural registers.
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered one-cycle pulse when HI/LO are written by mul/div.
- `dbz`  out  1  registered sticky divide-by-zero flag for the last completed DIV/DIVU.
- `stall`  out  1  combinational: `busy & (start | rd_req)`.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - RUN: iterations; `busy` = 1.
  - FIX: sign fix-up and HI/LO write; `busy` = 1.
- IDLE, `start` with op 000–011:
  - Latch the operands. Signed ops latch absolute values, plus the result-sign and remainder-sign bits.
  - Clear the iteration counter and go to RUN.
  - Exception: DIV/DIVU with `op_b` = 0 goes directly to FIX and sets the internal dbz marker.
- IDLE, `start` with op 100/101: write `op_a` to HI/LO at that edge. No busy, no done, `dbz` unchanged.
- `start` while `busy`:
  - Ignored by this block.
  - `stall` is high, so upstream holds the instruction.
  - The instruction is re-sampled on the first IDLE cycle.
- RUN performs one iteration per cycle for WIDTH cycles; counter 0..WIDTH-1, then FIX.
  - Multiply: unsigned shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle (LSB first).
  - Divide: restoring division, one quotient bit per cycle (MSB first). The partial remainder is WIDTH+1 bits.
- FIX results:
  - MULT/MULTU: {HI,LO} = product. Signed ops take the 2·WIDTH two's-complement negation if sign(a) XOR sign(b).
  - DIV/DIVU: LO = quotient, HI = remainder.
    - Signed quotient is negated if sign(a) XOR sign(b).
    - Remainder takes the sign of the dividend.
  - Signed 0x80000000 / −1 yields LO = 0x80000000, HI = 0; the natural result of the algorithm, no special case.
  - Divide by zero: LO = all ones, HI = `op_a` as latched (original, not absolute), `dbz` = 1.
  - Any other completed DIV/DIVU clears `dbz`. MULT/MULTU leave `dbz` unchanged.
  - FIX asserts `done` for the next cycle and returns to IDLE.
- `flush` in RUN or FIX:
  - Return to IDLE at that edge.
  - HI/LO and `dbz` unchanged, no `done`.
  - `flush` has priority over FIX completion.
- `flush` in IDLE suppresses acceptance of a simultaneous `start`.
- `rd_data` reflects HI/LO immediately after a write edge. Write-then-read forwarding is not provided; `stall` covers the in-flight case.

## Timing
- Reset (`rst_n` = 0 at an edge, any state):
  - State IDLE.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `dbz` = 0, counter = 0.
  - Reset mid-operation discards the operation.
- Mul/div accepted at edge E0 (normal case):
  - `busy` = 1 after E0.
  - RUN occupies edges E1..E(WIDTH).
  - FIX at edge E(WIDTH+1) writes HI/LO, clears `busy` and sets `done`; `done` clears at the next edge.
  - Result latency is WIDTH+1 edges; 33 edges for WIDTH = 32.
- Divide-by-zero accepted at E0: FIX at E1, results and `done` after E1 (latency 1).
- The first new `start` is accepted on the cycle `done` is high, so back-to-back issue interval is WIDTH+2 cycles.

## Test plan
- MULT, `op_a` = 0xFFFFFFFD (−3), `op_b` = 7 → after 33 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` high exactly one cycle; `busy` high 33 cycles.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
  - Same operands with MULT → HI = 0, LO = 1.
- Normal divides:
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2 → LO = 3, HI = 1.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0; `dbz` = 0.
- DIV 5 / 0 → after 1 edge LO = 0xFFFFFFFF, HI = 5, `dbz` = 1, `done` pulse. A following DIVU 9 / 3 → LO = 3, HI = 0, `dbz` = 0.
- Hazards while busy:
  - `rd_req` = 1 during RUN → `stall` = 1 each cycle until `busy` drops; `rd_data` then shows the new LO.
  - MTHI 0x1234 issued while busy → stalled, then HI = 0x1234 the edge after acceptance.
- Cancellation, starting from HI = 0xAAAA, LO = 0x5555 and a MULT in flight:
  - `flush` at RUN counter 10 → IDLE next edge, HI/LO unchanged, no `done`.
  - `rst_n` = 0 mid-RUN → all outputs zero after that edge.
